gsim_residual: RTL and testbench

Downstream checker for the Gauss-Seidel solver. It snoops the solver's `b` input stream and captures its `x` result burst. It then computes the residual `r = b - A·x` for the fixed 16×16 banded system and reports the maximum absolute residual plus a pass/fail flag against a tolerance. It sits beside the solver in the top level, consumes `in_en`/`b_in` and `out_valid`/`x_out` unchanged, and never back-pressures either.

---
 rtl/gsim_residual_pkg.sv | 33 +++
 rtl/gsim_residual_if.sv | 25 ++
 rtl/gsim_residual_row.sv | 25 ++
 rtl/gsim_residual.sv | 121 ++++++++++++
 tb/tb_gsim_residual.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gsim_residual_pkg.sv
// rtl/gsim_residual_pkg.sv - shared sizes, band coefficients, FSM states and residual saturation helpers
package gsim_pkg;

  localparam int N   = 16;
  localparam int B_W = 16;
  localparam int X_W = 32;
  localparam int R_W = 40;

  localparam logic signed [R_W-1:0] C0 = 40'sd20;
  localparam logic signed [R_W-1:0] C1 = 40'sd13;
  localparam logic signed [R_W-1:0] C2 = 40'sd6;
  localparam logic signed [R_W-1:0] C3 = 40'sd1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CALC    = 2'd1,
    REPORT  = 2'd2
  } state_t;

  function automatic logic [31:0] abs_sat(input logic signed [R_W-1:0] r);
    logic signed [R_W-1:0] m;
    m = r[R_W-1] ? -r : r;
    if (m[R_W-1:32] != '0) return 32'hFFFF_FFFF;
    else                   return m[31:0];
  endfunction

  function automatic logic [31:0] sat_s32(input logic signed [R_W-1:0] r);
    if (r > 40'sh00_7FFF_FFFF)       return 32'h7FFF_FFFF;
    else if (r < -40'sh00_8000_0000) return 32'h8000_0000;
    else                             return r[31:0];
  endfunction

endpackage

// File: rtl/gsim_residual_if.sv
// rtl/gsim_residual_if.sv - solver snoop strobes and residual report bundle
// GSIM_RES_VEC_EN adds the per-row res_valid/res_out signals.
interface gsim_residual_if;
  logic        in_en;
  logic [15:0] b_in;
  logic        out_valid;
  logic [31:0] x_out;
  logic        done;
  logic [31:0] res_max;
  logic        pass;
`ifdef GSIM_RES_VEC_EN
  logic        res_valid;
  logic [31:0] res_out;

  modport master (output in_en, b_in, out_valid, x_out,
                  input  done, res_max, pass, res_valid, res_out);
  modport slave  (input  in_en, b_in, out_valid, x_out,
                  output done, res_max, pass, res_valid, res_out);
`else
  modport master (output in_en, b_in, out_valid, x_out,
                  input  done, res_max, pass);
  modport slave  (input  in_en, b_in, out_valid, x_out,
                  output done, res_max, pass);
`endif
endinterface

// File: rtl/gsim_residual_row.sv
// rtl/gsim_residual_row.sv - combinational residual for one row of the 7-diagonal band
module gsim_res_row
  import gsim_pkg::*;
(
  input  logic [B_W-1:0]        i_b_k,
  input  logic [X_W-1:0]        i_x_tap [7],
  input  logic [6:0]            i_tap_vld,
  output logic signed [R_W-1:0] o_r_k
);

  logic signed [R_W-1:0] w_t [7];
  logic signed [R_W-1:0] w_ax;

  // Taps falling outside the matrix contribute zero rather than wrapped data.
  always_comb begin
    for (int j = 0; j < 7; j++) begin
      w_t[j] = i_tap_vld[j] ? {{(R_W-X_W){i_x_tap[j][X_W-1]}}, i_x_tap[j]} : '0;
    end
  end

  assign w_ax  = C0 * w_t[3] - C1 * (w_t[2] + w_t[4])
               + C2 * (w_t[1] + w_t[5]) - C3 * (w_t[0] + w_t[6]);
  assign o_r_k = signed'({{(R_W-B_W-16){i_b_k[B_W-1]}}, i_b_k, 16'h0000}) - w_ax;

endmodule

// File: rtl/gsim_residual.sv
// rtl/gsim_residual.sv - residual checker: buffers b/x, evaluates r=b-Ax row by row, reports max |r|
// GSIM_RES_VEC_EN adds per-row signed residual output.
module gsim_residual
  import gsim_pkg::*;
#(
  parameter logic [31:0] TOL = 32'h0000_1000
)(
  input  logic           clk,
  input  logic           reset,
  gsim_residual_if.slave bus
);

  state_t                r_state, w_state_nxt;
  logic                  w_start;
  logic [3:0]            r_b_cnt, r_x_cnt, r_row;
  logic                  r_wr_bank;
  logic                  w_rd_bank;
  logic [B_W-1:0]        r_b [2][N];
  logic [X_W-1:0]        r_x [N];
  logic [X_W-1:0]        w_tap [7];
  logic [6:0]            w_tap_vld;
  logic signed [R_W-1:0] w_r_k;
  logic signed [R_W-1:0] r_res;
  logic                  r_res_vld;
  logic [31:0]           w_res_abs, w_max_nxt;
  logic [31:0]           r_max, r_res_max;
  logic                  r_done, r_pass;

  always_ff @(posedge clk) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      COLLECT: if (bus.out_valid && r_x_cnt == 4'd15) begin
                 w_state_nxt = CALC;
                 w_start     = 1'b1;
               end
      CALC:    if (r_row == 4'd15) w_state_nxt = REPORT;
      REPORT:  w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_b_cnt   <= '0;
      r_x_cnt   <= '0;
      r_row     <= '0;
      r_wr_bank <= 1'b0;
    end else begin
      if (bus.out_valid) r_x_cnt <= r_x_cnt + 4'd1;
      // The closing x beat hands the filled bank to CALC; new b beats restart in the other bank.
      if (w_start) begin
        r_wr_bank <= ~r_wr_bank;
        r_b_cnt   <= '0;
      end else if (bus.in_en) begin
        r_b_cnt <= r_b_cnt + 4'd1;
      end
      r_row <= (r_state == CALC) ? r_row + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_en)     r_b[r_wr_bank][r_b_cnt] <= bus.b_in;
    if (bus.out_valid) r_x[r_x_cnt]            <= bus.x_out;
  end

  assign w_rd_bank = ~r_wr_bank;

  for (genvar j = 0; j < 7; j++) begin : g_tap
    logic [5:0] w_idx;
    assign w_idx        = {2'b00, r_row} + 6'(j) - 6'd3;
    assign w_tap_vld[j] = (w_idx < 6'd16);
    assign w_tap[j]     = r_x[w_idx[3:0]];
  end

  gsim_res_row u_row (
    .i_b_k     (r_b[w_rd_bank][r_row]),
    .i_x_tap   (w_tap),
    .i_tap_vld (w_tap_vld),
    .o_r_k     (w_r_k)
  );

  assign w_res_abs = abs_sat(r_res);
  assign w_max_nxt = (r_res_vld && w_res_abs > r_max) ? w_res_abs : r_max;

  // Row 15's residual is still in r_res during REPORT, so the report folds it in directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res     <= '0;
      r_res_vld <= 1'b0;
      r_max     <= '0;
      r_res_max <= '0;
      r_pass    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_res_vld <= (r_state == CALC);
      if (r_state == CALC) r_res <= w_r_k;
      if (w_start)          r_max <= '0;
      else if (r_res_vld)   r_max <= w_max_nxt;
      r_done <= (r_state == REPORT);
      if (r_state == REPORT) begin
        r_res_max <= w_max_nxt;
        r_pass    <= (w_max_nxt <= TOL);
      end
    end
  end

  assign bus.done    = r_done;
  assign bus.res_max = r_res_max;
  assign bus.pass    = r_pass;
`ifdef GSIM_RES_VEC_EN
  assign bus.res_valid = r_res_vld;
  assign bus.res_out   = sat_s32(r_res);
`endif

endmodule

// File: tb/tb_gsim_residual.sv
// tb/tb_gsim_residual.sv - directed-vector bench for gsim_residual
module tb_gsim_residual;

  typedef logic [15:0] bvec_t [16];
  typedef logic [31:0] xvec_t [16];

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  gsim_residual_if bus();

  gsim_residual u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_en     = 1'b0;
    bus.b_in      = '0;
    bus.out_valid = 1'b0;
    bus.x_out     = '0;
  endtask

  task automatic send_b(input bvec_t b);
    for (int i = 0; i < 16; i++) begin
      bus.in_en = 1'b1;
      bus.b_in  = b[i];
      tick();
    end
    bus.in_en = 1'b0;
  endtask

  task automatic send_x(input xvec_t x);
    for (int i = 0; i < 16; i++) begin
      bus.out_valid = 1'b1;
      bus.x_out     = x[i];
      tick();
    end
    bus.out_valid = 1'b0;
  endtask

  // Entered in cycle T+1; lat is the T-relative cycle of done, or -1 if none within 40 cycles.
  task automatic wait_done(input bit drive_b, input bvec_t nb, input int rst_cyc,
                           output int lat, output logic [31:0] row7, output int vcnt);
    lat  = -1;
    row7 = '0;
    vcnt = 0;
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      if (drive_b && cyc <= 16) begin
        bus.in_en = 1'b1;
        bus.b_in  = nb[cyc-1];
      end else begin
        bus.in_en = 1'b0;
      end
      reset = (cyc == rst_cyc);
`ifdef GSIM_RES_VEC_EN
      if (bus.res_valid) vcnt++;
      if (cyc == 9) row7 = bus.res_out;
`endif
      if (bus.done) lat = cyc;
      else          tick();
    end
    bus.in_en = 1'b0;
    reset     = 1'b0;
  endtask

  function automatic bvec_t b_ones();
    return '{16'd12, 16'hFFFF, 16'd5, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4,
             16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd5, 16'hFFFF, 16'd12};
  endfunction

  function automatic bvec_t b_spiky();
    bvec_t b;
    for (int i = 0; i < 16; i++) b[i] = 16'd1;
    b[5]  = 16'hFFFD;
    b[10] = 16'd2;
    return b;
  endfunction

  function automatic xvec_t x_fill(input logic [31:0] v);
    xvec_t x;
    for (int i = 0; i < 16; i++) x[i] = v;
    return x;
  endfunction

  task automatic check_result(input string name, input int lat,
                              input logic [31:0] want_max, input logic want_pass);
    total++;
    if (lat !== 18) begin
      bad++;
      $display("FAIL %s_latency: got %0d want 18", name, lat);
    end
    total++;
    if (bus.res_max !== want_max) begin
      bad++;
      $display("FAIL %s_res_max: got %h want %h", name, bus.res_max, want_max);
    end
    total++;
    if (bus.pass !== want_pass) begin
      bad++;
      $display("FAIL %s_pass: got %b want %b", name, bus.pass, want_pass);
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++;
    if (bus.res_max !== 32'h0) begin bad++; $display("FAIL reset_res_max: got %h want 0", bus.res_max); end
    total++;
    if (bus.pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %b want 0", bus.pass); end
`ifdef GSIM_RES_VEC_EN
    total++;
    if (bus.res_valid !== 1'b0 || bus.res_out !== 32'h0) begin
      bad++;
      $display("FAIL reset_vec: got %b/%h want 0/0", bus.res_valid, bus.res_out);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int lat, vc;
    logic [31:0] r7;
    send_b('{default: 16'h0});
    send_x(x_fill(32'h0));
    wait_done(1'b0, '{default: 16'h0}, 0, lat, r7, vc);
    check_result("zero", lat, 32'h0, 1'b1);
    tick();
    total++;
    if (bus.done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_ones();
    int lat, vc;
    logic [31:0] r7;
    send_b(b_ones());
    send_x(x_fill(32'h0001_0000));
    wait_done(1'b0, '{default: 16'h0}, 0, lat, r7, vc);
    check_result("ones", lat, 32'h0, 1'b1);
    tick();
  endtask

  task automatic test_perturb();
    int lat, vc;
    logic [31:0] r7;
    xvec_t x;
    x    = x_fill(32'h0001_0000);
    x[7] = 32'h0001_0100;
    send_b(b_ones());
    send_x(x);
    wait_done(1'b0, '{default: 16'h0}, 0, lat, r7, vc);
    check_result("perturb", lat, 32'h0000_1400, 1'b0);
`ifdef GSIM_RES_VEC_EN
    total++;
    if (r7 !== 32'hFFFF_EC00) begin bad++; $display("FAIL perturb_row7: got %h want ffffec00", r7); end
    total++;
    if (vc !== 16) begin bad++; $display("FAIL perturb_vec_count: got %0d want 16", vc); end
`endif
    tick();
  endtask

  task automatic test_tol_edge();
    int lat, vc;
    logic [31:0] r7;
    xvec_t x;
    x    = x_fill(32'h0001_0000);
    x[7] = 32'h0001_00CC;
    send_b(b_ones());
    send_x(x);
    wait_done(1'b0, '{default: 16'h0}, 0, lat, r7, vc);
    check_result("tol_edge", lat, 32'h0000_0FF0, 1'b1);
    tick();
  endtask

  task automatic test_saturate();
    int lat, vc;
    logic [31:0] r7;
    send_b('{default: 16'h0});
    send_x(x_fill(32'h7FFF_FFFF));
    wait_done(1'b0, '{default: 16'h0}, 0, lat, r7, vc);
    check_result("saturate", lat, 32'hFFFF_FFFF, 1'b0);
    tick();
  endtask

  task automatic test_b_only();
    int lat, vc;
    logic [31:0] r7;
    send_b(b_spiky());
    send_x(x_fill(32'h0));
    wait_done(1'b0, '{default: 16'h0}, 0, lat, r7, vc);
    check_result("b_only", lat, 32'h0003_0000, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, vc;
    logic [31:0] r7;
    xvec_t x;
    x    = x_fill(32'h0001_0000);
    x[7] = 32'h0001_0100;
    send_b(b_ones());
    send_x(x);
    wait_done(1'b1, b_spiky(), 0, lat, r7, vc);
    check_result("b2b_first", lat, 32'h0000_1400, 1'b0);
    tick();
    send_x(x_fill(32'h0));
    wait_done(1'b0, '{default: 16'h0}, 0, lat, r7, vc);
    check_result("b2b_second", lat, 32'h0003_0000, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_calc();
    int lat, vc;
    logic [31:0] r7;
    xvec_t x;
    x    = x_fill(32'h0001_0000);
    x[7] = 32'h0001_0100;
    send_b(b_ones());
    send_x(x);
    wait_done(1'b0, '{default: 16'h0}, 8, lat, r7, vc);
    total++;
    if (lat !== -1) begin bad++; $display("FAIL abort_no_done: got done at %0d want none", lat); end
    total++;
    if (bus.res_max !== 32'h0) begin bad++; $display("FAIL abort_res_max: got %h want 0", bus.res_max); end
    total++;
    if (bus.pass !== 1'b0) begin bad++; $display("FAIL abort_pass: got %b want 0", bus.pass); end
    send_b(b_ones());
    send_x(x_fill(32'h0001_0000));
    wait_done(1'b0, '{default: 16'h0}, 0, lat, r7, vc);
    check_result("after_abort", lat, 32'h0, 1'b1);
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_zero();
    test_ones();
    test_perturb();
    test_tol_edge();
    test_saturate();
    test_b_only();
    test_back_to_back();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
